// File: rtl/character_sprite_renderer.sv
// Character sprite renderer: latches the character's display id, position and facing
// once per frame, then turns pixel requests into sprite-ROM addresses and returns an
// opaque-hit flag plus colour three cycles later.
// Optional build macro: SPRITE_MIRROR_EN (horizontal mirroring for left-facing sprites).
module character_sprite_renderer #(
    parameter int SPRITE_W       = 32,
    parameter int SPRITE_H       = 32,
    parameter int NUM_SPRITES    = 7,
    parameter int COORD_WIDTH    = 10,
    parameter int COLOR_WIDTH    = 12,
    parameter logic [COLOR_WIDTH-1:0] TRANSPARENT_COLOR = COLOR_WIDTH'(12'hF0F),
    parameter int ROM_ADDR_WIDTH = $clog2(NUM_SPRITES * SPRITE_W * SPRITE_H)
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      character_clk,
    input  logic [2:0]                char_display_id,
    input  logic                      char_facing_left,
    input  logic [COORD_WIDTH-1:0]    char_x,
    input  logic [COORD_WIDTH-1:0]    char_y,
    input  logic                      pix_valid_in,
    input  logic [COORD_WIDTH-1:0]    pix_x,
    input  logic [COORD_WIDTH-1:0]    pix_y,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [COLOR_WIDTH-1:0]    rom_data,
    output logic                      pix_valid_out,
    output logic                      pix_hit,
    output logic [COLOR_WIDTH-1:0]    pix_color
);

    localparam int LX_W   = $clog2(SPRITE_W);
    localparam int LY_W   = $clog2(SPRITE_H);
    localparam int FULL_W = 3 + LX_W + LY_W;

    // Box limits are compared one bit wider so a sprite near the right/bottom edge
    // never wraps back to coordinate 0.
    localparam logic [COORD_WIDTH:0] SW_EXT        = (COORD_WIDTH + 1)'(SPRITE_W);
    localparam logic [COORD_WIDTH:0] SH_EXT        = (COORD_WIDTH + 1)'(SPRITE_H);
    localparam logic [3:0]           NUM_SPRITES_C = 4'(NUM_SPRITES);
    localparam logic [LX_W-1:0]      LX_MAX        = LX_W'(SPRITE_W - 1);

    typedef enum logic {StWaitFrame, StActive} state_t;

    state_t state_q, state_d;

    // Per-frame shadow copy of the character description
    logic [2:0]             id_q;
    logic [COORD_WIDTH-1:0] sx_q;
    logic [COORD_WIDTH-1:0] sy_q;
    logic                   facing_q;

    // Stage 1 combinational results
    logic            in_box_c;
    logic            id_ok_c;
    logic [LX_W-1:0] lx_c;
    logic [LX_W-1:0] lx_m;
    logic [LY_W-1:0] ly_c;

    // Pipeline registers
    logic            s1_valid, s1_live, s1_in_box, s1_id_ok;
    logic [2:0]      s1_id;
    logic [LX_W-1:0] s1_lx;
    logic [LY_W-1:0] s1_ly;
    logic            s2_valid, s2_hit;
    logic            s3_valid, s3_hit;

    logic [FULL_W-1:0] addr_full;
    logic              addr_ok;

    // Frame-state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= StWaitFrame;
        else         state_q <= state_d;
    end

    // Leave the waiting state on the first frame tick; stay active until reset
    always_comb begin
        state_d = state_q;
        if (state_q == StWaitFrame && character_clk) state_d = StActive;
    end

    // Shadow registers update only on the frame tick, so a frame never tears
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            id_q     <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            facing_q <= 1'b0;
        end else if (character_clk) begin
            id_q     <= char_display_id;
            sx_q     <= char_x;
            sy_q     <= char_y;
            facing_q <= char_facing_left;
        end
    end

    // Box test and local sprite coordinates against the current shadow values
    always_comb begin
        in_box_c = ({1'b0, pix_x} >= {1'b0, sx_q}) && ({1'b0, pix_x} < ({1'b0, sx_q} + SW_EXT)) &&
                   ({1'b0, pix_y} >= {1'b0, sy_q}) && ({1'b0, pix_y} < ({1'b0, sy_q} + SH_EXT));
        // Only the low bits of the offset matter, so subtract just those
        lx_c     = pix_x[LX_W-1:0] - sx_q[LX_W-1:0];
        ly_c     = pix_y[LY_W-1:0] - sy_q[LY_W-1:0];
        id_ok_c  = {1'b0, id_q} < NUM_SPRITES_C;
    end

`ifdef SPRITE_MIRROR_EN
    assign lx_m = facing_q ? (LX_MAX - lx_c) : lx_c;
`else
    logic unused_facing;
    assign unused_facing = facing_q ^ (LX_MAX == '0);
    assign lx_m          = lx_c;
`endif

    // Stage 1: capture box test, local coordinates and the id used by this pixel
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_valid  <= 1'b0;
            s1_live   <= 1'b0;
            s1_in_box <= 1'b0;
            s1_id_ok  <= 1'b0;
            s1_id     <= '0;
            s1_lx     <= '0;
            s1_ly     <= '0;
        end else begin
            s1_valid  <= pix_valid_in;
            s1_live   <= (state_q == StActive);
            s1_in_box <= in_box_c;
            s1_id_ok  <= id_ok_c;
            s1_id     <= id_q;
            s1_lx     <= lx_m;
            s1_ly     <= ly_c;
        end
    end

    // Sprite sizes are powers of two, so id*W*H + ly*W + lx is a plain concatenation
    assign addr_full = {s1_id, s1_ly, s1_lx};
    assign addr_ok   = s1_in_box && s1_id_ok;

    // Stage 2: ROM address (held on misses) and the pending hit flag
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rom_addr <= '0;
            s2_valid <= 1'b0;
            s2_hit   <= 1'b0;
        end else begin
            if (addr_ok) rom_addr <= ROM_ADDR_WIDTH'(addr_full);
            s2_valid <= s1_valid;
            s2_hit   <= s1_valid && s1_live && addr_ok;
        end
    end

    // Stage 3: align flags with the ROM's one-cycle read latency
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s3_valid <= 1'b0;
            s3_hit   <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
            s3_hit   <= s2_hit;
        end
    end

    // Output: transparent ROM texels never count as a hit; colour is zero on a miss
    always_comb begin
        pix_valid_out = s3_valid;
        pix_hit       = s3_hit && (rom_data != TRANSPARENT_COLOR);
        pix_color     = pix_hit ? rom_data : '0;
    end

endmodule

// File: tb/tb_character_sprite_renderer.sv
// Self-checking bench for character_sprite_renderer (default parameters).
module tb_character_sprite_renderer;

    logic        sys_clk;
    logic        sys_rst;
    logic        character_clk;
    logic [2:0]  char_display_id;
    logic        char_facing_left;
    logic [9:0]  char_x, char_y;
    logic        pix_valid_in;
    logic [9:0]  pix_x, pix_y;
    logic [12:0] rom_addr;
    logic [11:0] rom_data;
    logic        pix_valid_out;
    logic        pix_hit;
    logic [11:0] pix_color;

    int total = 0;
    int bad   = 0;

    character_sprite_renderer dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .character_clk    (character_clk),
        .char_display_id  (char_display_id),
        .char_facing_left (char_facing_left),
        .char_x           (char_x),
        .char_y           (char_y),
        .pix_valid_in     (pix_valid_in),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .pix_valid_out    (pix_valid_out),
        .pix_hit          (pix_hit),
        .pix_color        (pix_color)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Sprite ROM model: one transparent texel at 2378, otherwise 0x1nn with nn = addr[7:0]
    function automatic logic [11:0] rom_fn(input logic [12:0] a);
        if (a == 13'd2378) return 12'hF0F;
        return 12'h100 | {4'h0, a[7:0]};
    endfunction

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) rom_data <= 12'h000;
        else         rom_data <= rom_fn(rom_addr);
    end

    typedef struct {
        logic        do_latch;
        logic [2:0]  id;
        logic [9:0]  cx;
        logic [9:0]  cy;
        logic        face;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [12:0] addr;
        logic        hit;
        logic [11:0] color;
    } vec_t;

`ifdef SPRITE_MIRROR_EN
    localparam logic [12:0] M0 = 13'd31;
    localparam logic [12:0] M1 = 13'd32;
    localparam logic [11:0] C0 = 12'h11F;
    localparam logic [11:0] C1 = 12'h120;
`else
    localparam logic [12:0] M0 = 13'd0;
    localparam logic [12:0] M1 = 13'd63;
    localparam logic [11:0] C0 = 12'h100;
    localparam logic [11:0] C1 = 12'h13F;
`endif

    vec_t vecs[13];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic latch(input logic [2:0] id, input logic [9:0] x, input logic [9:0] y,
                         input logic f);
        char_display_id  = id;
        char_x           = x;
        char_y           = y;
        char_facing_left = f;
        character_clk    = 1'b1;
        tick();
        character_clk    = 1'b0;
    endtask

    int v_cnt, h_cnt;
    logic [7:0] pat;
    logic       exp_v;

    initial begin
        // id 2 at (100,50)
        vecs[0]  = '{1'b1, 3'd2, 10'd100, 10'd50, 1'b0, 10'd100, 10'd50, 13'd2048, 1'b1, 12'h100};
        vecs[1]  = '{1'b0, 3'd0, 10'd0, 10'd0, 1'b0, 10'd131, 10'd81, 13'd3071, 1'b1, 12'h1FF};
        vecs[2]  = '{1'b0, 3'd0, 10'd0, 10'd0, 1'b0, 10'd132, 10'd50, 13'd3071, 1'b0, 12'h000};
        vecs[3]  = '{1'b0, 3'd0, 10'd0, 10'd0, 1'b0, 10'd99, 10'd50, 13'd3071, 1'b0, 12'h000};
        vecs[4]  = '{1'b0, 3'd0, 10'd0, 10'd0, 1'b0, 10'd110, 10'd60, 13'd2378, 1'b0, 12'h000};
        vecs[5]  = '{1'b0, 3'd0, 10'd0, 10'd0, 1'b0, 10'd115, 10'd70, 13'd2703, 1'b1, 12'h18F};
        vecs[6]  = '{1'b0, 3'd0, 10'd0, 10'd0, 1'b0, 10'd100, 10'd49, 13'd2703, 1'b0, 12'h000};
        vecs[7]  = '{1'b0, 3'd0, 10'd0, 10'd0, 1'b0, 10'd100, 10'd82, 13'd2703, 1'b0, 12'h000};
        // id 0 at (0,0) facing left
        vecs[8]  = '{1'b1, 3'd0, 10'd0, 10'd0, 1'b1, 10'd0, 10'd0, M0, 1'b1, C0};
        vecs[9]  = '{1'b0, 3'd0, 10'd0, 10'd0, 1'b0, 10'd31, 10'd1, M1, 1'b1, C1};
        // id 1 partly off the right edge
        vecs[10] = '{1'b1, 3'd1, 10'd1010, 10'd0, 1'b0, 10'd1015, 10'd0, 13'd1029, 1'b1, 12'h105};
        vecs[11] = '{1'b0, 3'd0, 10'd0, 10'd0, 1'b0, 10'd2, 10'd0, 13'd1029, 1'b0, 12'h000};
        vecs[12] = '{1'b0, 3'd0, 10'd0, 10'd0, 1'b0, 10'd1023, 10'd0, 13'd1037, 1'b1, 12'h10D};

        sys_rst = 1'b1;
        character_clk = 1'b0;
        char_display_id = 3'd0;
        char_facing_left = 1'b0;
        char_x = '0;
        char_y = '0;
        pix_valid_in = 1'b0;
        pix_x = '0;
        pix_y = '0;
        #12;
        chk("reset_valid", {31'b0, pix_valid_out}, 0);
        chk("reset_hit", {31'b0, pix_hit}, 0);
        chk("reset_color", {20'b0, pix_color}, 0);
        chk("reset_addr", {19'b0, rom_addr}, 0);
        tick();
        sys_rst = 1'b0;

        // Before any frame tick: valid follows input by 3 cycles, never a hit
        pat = 8'b1011_0110;
        for (int j = 0; j < 11; j++) begin
            pix_valid_in = (j < 8) ? pat[j] : 1'b0;
            tick();
            exp_v = (j >= 2 && j < 10) ? pat[j-2] : 1'b0;
            chk("wait_valid", {31'b0, pix_valid_out}, {31'b0, exp_v});
            chk("wait_hit", {31'b0, pix_hit}, 0);
        end

        // Directed vector table, one pixel at a time
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_latch) latch(vecs[i].id, vecs[i].cx, vecs[i].cy, vecs[i].face);
            pix_x = vecs[i].x;
            pix_y = vecs[i].y;
            pix_valid_in = 1'b1;
            tick();
            pix_valid_in = 1'b0;
            tick();
            chk($sformatf("v%0d_addr", i), {19'b0, rom_addr}, {19'b0, vecs[i].addr});
            tick();
            chk($sformatf("v%0d_valid", i), {31'b0, pix_valid_out}, 1);
            chk($sformatf("v%0d_hit", i), {31'b0, pix_hit}, {31'b0, vecs[i].hit});
            chk($sformatf("v%0d_color", i), {20'b0, pix_color}, {20'b0, vecs[i].color});
        end

        // Frame tick in the same cycle as a request: that pixel still uses the old id
        latch(3'd2, 10'd100, 10'd50, 1'b0);
        char_display_id = 3'd4;
        character_clk = 1'b1;
        pix_x = 10'd100;
        pix_y = 10'd50;
        pix_valid_in = 1'b1;
        tick();
        character_clk = 1'b0;
        tick();
        pix_valid_in = 1'b0;
        chk("same_old_addr", {19'b0, rom_addr}, 2048);
        tick();
        chk("same_new_addr", {19'b0, rom_addr}, 4096);
        chk("same_old_hit", {31'b0, pix_hit}, 1);
        chk("same_old_color", {20'b0, pix_color}, 12'h100);
        tick();
        chk("same_new_hit", {31'b0, pix_hit}, 1);
        chk("same_new_valid", {31'b0, pix_valid_out}, 1);
        tick();

        // Invalid id: a whole streamed box produces no hits
        latch(3'd7, 10'd100, 10'd50, 1'b0);
        v_cnt = 0;
        h_cnt = 0;
        for (int i = 0; i < 1027; i++) begin
            pix_valid_in = (i < 1024);
            pix_x = 10'(100 + (i % 32));
            pix_y = 10'(50 + ((i / 32) % 32));
            tick();
            if (pix_valid_out) v_cnt++;
            if (pix_hit) h_cnt++;
        end
        pix_valid_in = 1'b0;
        tick();
        if (pix_valid_out) v_cnt++;
        chk("id7_hits", h_cnt, 0);
        chk("id7_valids", v_cnt, 1024);

        // Reset in the middle of a stream drops every in-flight pixel
        latch(3'd2, 10'd100, 10'd50, 1'b0);
        pix_x = 10'd100;
        pix_y = 10'd50;
        pix_valid_in = 1'b1;
        tick();
        tick();
        tick();
        sys_rst = 1'b1;
        #1;
        chk("midrst_valid", {31'b0, pix_valid_out}, 0);
        chk("midrst_addr", {19'b0, rom_addr}, 0);
        pix_valid_in = 1'b0;
        tick();
        sys_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_valid", {31'b0, pix_valid_out}, 0);
        end
        // Shadow is back to id 0 at (0,0) and no frame tick yet: no hit
        pix_x = 10'd0;
        pix_y = 10'd0;
        pix_valid_in = 1'b1;
        tick();
        pix_valid_in = 1'b0;
        tick();
        tick();
        chk("post_rst_req_valid", {31'b0, pix_valid_out}, 1);
        chk("post_rst_req_hit", {31'b0, pix_hit}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/character_sprite_renderer.md
Name: character_sprite_renderer

Overview:
- Consumer side of the character display-id interface: takes the 3-bit char_display_id and character position and turns them into per-pixel sprite colour for the VGA pixel pipeline.
- Latches id, position and facing once per frame on the character_clk tick so the sprite never tears mid-frame.
- Generates synchronous sprite-ROM addresses and returns colour plus a hit flag with fixed latency.

Parameters:
- SPRITE_W, 32, sprite width in pixels (power of 2).
- SPRITE_H, 32, sprite height in pixels (power of 2).
- NUM_SPRITES, 7, number of valid display ids (0..6).
- COORD_WIDTH, 10, width of screen/pixel coordinates (unsigned).
- COLOR_WIDTH, 12, RGB444 colour width.
- TRANSPARENT_COLOR, 12'hF0F, ROM colour treated as transparent.
- ROM_ADDR_WIDTH, $clog2(NUM_SPRITES*SPRITE_W*SPRITE_H), sprite ROM address width.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  asynchronous active-high reset.
- character_clk  input  1  one-cycle frame-update tick (sys_clk domain).
- char_display_id  input  3  display id from the display state controller.
- char_facing_left  input  1  1 = character faces left.
- char_x  input  COORD_WIDTH  sprite top-left x.
- char_y  input  COORD_WIDTH  sprite top-left y.
- pix_valid_in  input  1  pixel request valid.
- pix_x  input  COORD_WIDTH  requested pixel x.
- pix_y  input  COORD_WIDTH  requested pixel y.
- rom_addr  output  ROM_ADDR_WIDTH  sprite ROM address (registered).
- rom_data  input  COLOR_WIDTH  ROM colour, valid 1 cycle after rom_addr.
- pix_valid_out  output  1  output pixel valid.
- pix_hit  output  1  opaque sprite pixel at this coordinate.
- pix_color  output  COLOR_WIDTH  sprite colour; 0 when pix_hit=0.

Behaviour:
- Reset: all outputs 0; shadow id=0, x=0, y=0, facing=0; FSM=WAIT_FRAME; pipeline valids cleared.
- Reset asserted mid-operation clears all in-flight pixels; no stale pix_valid_out after release.
- FSM states:
  - WAIT_FRAME: after reset; pix_hit forced 0 but pix_valid_out still tracks pix_valid_in with latency 3. Moves to ACTIVE on the first character_clk.
  - ACTIVE: normal rendering; remains until reset.
- Shadow registers: on character_clk=1, sample char_display_id, char_x, char_y, char_facing_left. They are used from the next cycle on. Pixels already in flight keep the values captured in stage 1.
- Stage 1, cycle N+1, registered:
  - in_box = pix_x >= sx, pix_x < sx+SPRITE_W, pix_y >= sy, pix_y < sy+SPRITE_H.
  - Compare in COORD_WIDTH+1 bits so sx+SPRITE_W never wraps.
  - Compute lx = pix_x - sx and ly = pix_y - sy, truncated to log2 width/height.
  - id_ok = shadow id < NUM_SPRITES.
- Stage 2, cycle N+2: rom_addr = id*SPRITE_W*SPRITE_H + ly*SPRITE_W + lx. When not (in_box && id_ok), rom_addr holds its previous value and the pixel is marked miss.
- Stage 3, cycle N+3: pix_valid_out = delayed pix_valid_in. pix_hit = hit && id_ok && in_box && rom_data != TRANSPARENT_COLOR. pix_color = rom_data when pix_hit, else 0.
- Latency: fixed at 3 cycles. Fully pipelined, one pixel per cycle, no backpressure. pix_valid_in=0 bubbles propagate unchanged.
- Boundaries:
  - Sprite partly off-screen (sx+SPRITE_W > 2^COORD_WIDTH): only on-screen pixels hit; no wrap to x=0.
  - Invalid id (7): every pixel misses.
  - character_clk in the same cycle as a pixel request: that pixel uses the OLD shadow values.

Optional Feature:
- Macro SPRITE_MIRROR_EN.
- Defined: when shadow facing=1, lx is replaced by SPRITE_W-1-lx before address generation (horizontal mirror).
- Not defined: char_facing_left is ignored and sprites are always drawn unmirrored. Latency and all other behaviour are identical.

Test Plan:
- Reset then pixel requests before any character_clk: pix_valid_out follows pix_valid_in delayed 3 cycles, pix_hit=0 throughout.
- character_clk with id=2, char_x=100, char_y=50; request (100,50): rom_addr=2048 at N+2. With rom_data=12'h123: pix_hit=1, pix_color=12'h123 at N+3. Request (131,81): addr=3071. Requests (132,50) and (99,50): pix_hit=0.
- Request (110,60) with rom_data=12'hF0F: pix_hit=0, pix_color=0.
- Latch id=7, stream a full 32x32 box: zero hits.
- character_clk with new id=4 in the same cycle as request (100,50): that pixel uses id=2 (addr 2048); the next request uses id=4 (addr 4096).
- With SPRITE_MIRROR_EN, facing=1, id=0, position (0,0): request (0,0) gives rom_addr=31, request (31,1) gives rom_addr=32. Without the macro: addr=0 and addr=63. Also place char_x=1010: request (1015,0) hits, request (2,0) misses.
